// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage.
// Registers EX results, runs multi-cycle loads/stores, feeds WB.
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        reg_write,
    output logic        stall_flag,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    // FSM and down-counter
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Captured instruction
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [4:0]    rd_q, rd_d;
    logic          mr_q, mr_d;
    logic          mw_q, mw_d;
    logic          m2r_q, m2r_d;
    logic          rw_q, rw_d;

    // Write-back registers
    logic          wb_valid_q, wb_valid_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic          wb_rw_q, wb_rw_d;
    logic          mis_q, mis_d;

    // Data memory
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic          mem_we;

    assign idx   = addr_q[AW+1:2];
    assign rdata = mem_q[idx];

    // Next-state: capture in IDLE, count down and complete in BUSY
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        rd_d       = rd_q;
        mr_d       = mr_q;
        mw_d       = mw_q;
        m2r_d      = m2r_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        mis_d      = mis_q;
        mem_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (mem_read || mem_write) begin
                        addr_d  = alu_result;
                        sdata_d = store_data;
                        rd_d    = rd;
                        mr_d    = mem_read;
                        mw_d    = mem_write;
                        m2r_d   = mem_to_reg;
                        rw_d    = reg_write;
                        cnt_d   = CNT_INIT;
                        state_d = BUSY;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_rd_d    = rd;
                        wb_rw_d    = reg_write;
                        mis_d      = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Read is combinational off the array, so a
                    // simultaneous write still returns the old word.
                    state_d    = IDLE;
                    mem_we     = mw_q;
                    wb_valid_d = 1'b1;
                    wb_data_d  = (mr_q && m2r_q) ? rdata : addr_q;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = rw_q;
                    mis_d      = |addr_q[1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline and FSM registers with asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            rd_q       <= '0;
            mr_q       <= 1'b0;
            mw_q       <= 1'b0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            rd_q       <= rd_d;
            mr_q       <= mr_d;
            mw_q       <= mw_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
        end
    end

    // Memory array write; never cleared, gated off while in reset
    always_ff @(posedge clk) begin
        if (reset && mem_we) begin
            mem_q[idx] <= sdata_q;
        end
    end

    assign stall_flag   = (state_q == BUSY);
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign misaligned   = mis_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It registers the execute result and control bits, performs data-memory loads and stores against an internal word array with a fixed multi-cycle latency, and presents write-back data to the WB stage. While an access is in flight it drives `stall_flag` back to the upstream stages, which hold their state.

## Interface
- `DEPTH`, 256: data-memory words (power of two).
- `MEM_LATENCY`, 2: cycles a load or store occupies the stage (≥1).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `ex_valid` in 1: execute stage presents an instruction this cycle.
- `alu_result` in 32: ALU result, or byte address for a load/store.
- `store_data` in 32: rt value written on a store.
- `rd` in 5: destination register.
- `mem_read`, `mem_write`, `mem_to_reg`, `reg_write` in 1 each: control bits from the control unit.
- `stall_flag` out 1: stage busy; upstream must hold its outputs.
- `wb_valid` out 1: one-cycle pulse; WB outputs are valid.
- `wb_data` out 32: load data, or `alu_result`.
- `wb_rd` out 5: destination register for WB.
- `wb_reg_write` out 1: register-file write enable for WB.
- `misaligned` out 1: accompanies `wb_valid`; the access address had nonzero bits [1:0].

## Operation
- FSM states:
  - IDLE: `stall_flag`=0; inputs are sampled only here.
  - BUSY: `stall_flag`=1; inputs are ignored.
- IDLE, `ex_valid`=1, `mem_read`=0, `mem_write`=0:
  - Capture on the edge.
  - Stay in IDLE.
  - `wb_data`=`alu_result`; `wb_valid`=1 for one cycle.
- IDLE, `ex_valid`=1, `mem_read` or `mem_write`=1:
  - Capture address, store data, `rd` and controls.
  - Load the down-counter with `MEM_LATENCY`-1.
  - Go to BUSY.
- BUSY, counter≠0: decrement.
- BUSY, counter=0, on that edge:
  - Perform the access and return to IDLE.
  - Pulse `wb_valid`.
- Word index is `alu_result[log2(DEPTH)+1:2]`. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- Bits [1:0] are ignored for the access. When nonzero, `misaligned`=1 with the result.
- Load result:
  - `wb_data` = mem[idx] if `mem_to_reg`=1, else `alu_result`.
- Store:
  - mem[idx] ← `store_data` on the completion edge.
  - `wb_data` = `alu_result`.
- `mem_read` and `mem_write` both set:
  - The write is performed.
  - `wb_data` returns the old word (read-before-write).
- `wb_rd` and `wb_reg_write` pass through from the captured values. A store with `reg_write`=1 is passed through unchanged; no checking is done.
- `ex_valid`=0 in IDLE: no capture, `wb_valid`=0. The other WB outputs hold their last values.
- Reset (asynchronous, `reset`=0):
  - State IDLE, counter 0.
  - `stall_flag`=0, `wb_valid`=0, `wb_data`=0, `wb_rd`=0, `wb_reg_write`=0, `misaligned`=0.
  - The memory array is not cleared.
- Reset during BUSY aborts the access: no write, no `wb_valid`.

## Timing
- Non-memory instruction captured at edge k: WB outputs valid after edge k; `wb_valid` high during cycle k..k+1.
- Memory instruction captured at edge k:
  - `stall_flag`=1 from edge k to edge k+`MEM_LATENCY` (exactly `MEM_LATENCY` cycles).
  - `wb_valid` pulses after edge k+`MEM_LATENCY`.
  - The next instruction is accepted no earlier than edge k+`MEM_LATENCY`+1.
- `MEM_LATENCY`=1: one BUSY cycle, so a load returns data one cycle after capture.
- `stall_flag` is a registered output: it depends only on state, with no combinational path from the inputs.
- Store-then-load to the same address: the load captured after the store completes reads the new data. No forwarding is needed.
- Back-to-back non-memory instructions: one per cycle, no stall.
- Reset deassertion takes effect at the next rising edge. No capture happens on an edge where `reset`=0.

## Test plan
- Reset: hold `reset`=0 mid-BUSY → `stall_flag`=0, `wb_valid`=0, all outputs 0. Release, then load from the address of the aborted store → old contents returned, no write happened.
- ALU pass-through: `alu_result`=0x0000002A, `rd`=5, `reg_write`=1, no memory op → next cycle `wb_valid`=1, `wb_data`=0x2A, `wb_rd`=5, `stall_flag` never asserted.
- Store then load, `MEM_LATENCY`=2:
  - Store 0xDEADBEEF to address 0x40 → `stall_flag` high for 2 cycles, `wb_reg_write`=0.
  - Then load 0x40, `mem_to_reg`=1, `rd`=9 → `wb_data`=0xDEADBEEF, `wb_rd`=9, 2 cycles after capture.
- Wrap and misalignment (`DEPTH`=256):
  - Store 0x11 at 0x00000004.
  - Load from 0x00000406 → `wb_data`=0x11, `misaligned`=1.
- Stall hold: keep `ex_valid`=1 with a new instruction during BUSY → it is captured only at the first IDLE edge, exactly once, with a single `wb_valid` pulse.
- Simultaneous read and write: address 0x08 holds 0x5; issue `mem_read`=`mem_write`=1 with `store_data`=0x7 → `wb_data`=0x5. A subsequent load returns 0x7.
